// File: rtl/spi_slave_if.sv
// SPI slave front end: shifts 10-bit command words in on MOSI and returns RAM read data on MISO.
// Optional frame_err output for frames aborted early is enabled by defining SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_if #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SS_n,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic [ADDR_SIZE+1:0]   rx_data,
    output logic                   rx_valid,
    input  logic                   tx_valid,
    input  logic [ADDR_SIZE-1:0]   tx_data
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    output logic                   frame_err
`endif
);

    localparam int W  = ADDR_SIZE + 2;
    localparam int CW = $clog2(W + 1) + 1;

    localparam logic [CW-1:0] RX_LAST = CW'(W - 1);
    localparam logic [CW-1:0] RX_DONE = CW'(W);
    localparam logic [CW-1:0] TX_LAST = CW'(ADDR_SIZE);
    localparam logic [CW-1:0] TX_DONE = CW'(ADDR_SIZE + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [W-2:0]         rx_shift_q;
    logic [ADDR_SIZE-1:0] tx_shift_q;
    logic                 rd_addr_seen_q;
    logic                 miso_q;
    logic [W-1:0]         rx_data_q;
    logic                 rx_valid_q;

`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic frame_err_q;
    logic frame_done;

    // A frame is complete once rx_valid fired (write/address) or the last read bit is on MISO.
    always_comb begin
        frame_done = 1'b0;
        if (state_q == WRITE || state_q == READ_ADD)
            frame_done = (rx_cnt_q == RX_DONE);
        else if (state_q == READ_DATA)
            frame_done = (tx_cnt_q >= TX_LAST);
    end

    assign frame_err = frame_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rx_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            rd_addr_seen_q <= 1'b0;
            miso_q         <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q    <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    miso_q   <= 1'b0;
                    rx_cnt_q <= '0;
                    tx_cnt_q <= '0;
                    if (!SS_n)
                        state_q <= CHK_CMD;
                end
                default: begin
                    if (SS_n) begin
                        state_q  <= IDLE;
                        rx_cnt_q <= '0;
                        tx_cnt_q <= '0;
                        miso_q   <= 1'b0;
                        // Deselect while the final read bit is on MISO still counts as a finished read.
                        if (state_q == READ_DATA && tx_cnt_q == TX_LAST)
                            rd_addr_seen_q <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
                        frame_err_q <= !frame_done;
`endif
                    end else if (state_q == CHK_CMD) begin
                        rx_shift_q <= {rx_shift_q[W-3:0], MOSI};
                        rx_cnt_q   <= CW'(1);
                        tx_cnt_q   <= '0;
                        if (!MOSI)
                            state_q <= WRITE;
                        else if (rd_addr_seen_q)
                            state_q <= READ_DATA;
                        else
                            state_q <= READ_ADD;
                    end else if (rx_cnt_q != RX_DONE) begin
                        rx_shift_q <= {rx_shift_q[W-3:0], MOSI};
                        rx_cnt_q   <= rx_cnt_q + 1'b1;
                        if (rx_cnt_q == RX_LAST) begin
                            rx_data_q  <= {rx_shift_q, MOSI};
                            rx_valid_q <= 1'b1;
                            if (state_q == READ_ADD)
                                rd_addr_seen_q <= 1'b1;
                        end
                    end else if (state_q == READ_DATA) begin
                        // tx_cnt_q: 0 waits for tx_valid, 1..ADDR_SIZE counts bits on MISO, then done.
                        if (tx_cnt_q == '0) begin
                            if (tx_valid) begin
                                miso_q     <= tx_data[ADDR_SIZE-1];
                                tx_shift_q <= {tx_data[ADDR_SIZE-2:0], 1'b0};
                                tx_cnt_q   <= CW'(1);
                            end
                        end else if (tx_cnt_q < TX_LAST) begin
                            miso_q     <= tx_shift_q[ADDR_SIZE-1];
                            tx_shift_q <= {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                            tx_cnt_q   <= tx_cnt_q + 1'b1;
                        end else if (tx_cnt_q == TX_LAST) begin
                            miso_q         <= 1'b0;
                            rd_addr_seen_q <= 1'b0;
                            tx_cnt_q       <= TX_DONE;
                        end
                    end
                end
            endcase
        end
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: directed and random frames against a frame-level model.
// frame_err checks are compiled in when SPI_SLAVE_FRAME_ERR_EN is defined.
module tb_spi_slave_if;

    localparam int AS = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          SS_n;
    logic          MOSI;
    logic          MISO;
    logic [AS+1:0] rx_data;
    logic          rx_valid;
    logic          tx_valid;
    logic [AS-1:0] tx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic          frame_err;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: whether a read address is pending, and the last delivered word.
    bit         rdSeen;
    logic [9:0] lastRx;

    spi_slave_if #(.ADDR_SIZE(AS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_valid (tx_valid),
        .tx_data  (tx_data)
`ifdef SPI_SLAVE_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    // Select the slave and shift n command bits, MSB first; tx_valid noise must be ignored.
    task automatic sendBits(input logic [9:0] word, input int n);
        SS_n = 1'b0;
        MOSI = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data = 8'($urandom);
        tick();
        for (int i = 0; i < n; i++) begin
            checks++;
            if ({rx_valid, MISO} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL shiftIdle bit %0d: rx_valid,MISO got %b expected 00", i, {rx_valid, MISO});
            end
            MOSI = word[9-i];
            tx_valid = 1'($urandom);
            tx_data = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
    endtask

    // Complete frame; read-data frames return txByte after txDelay idle cycles.
    task automatic fullFrame(input logic [9:0] word, input int txDelay,
                             input logic [7:0] txByte, input int extraHold);
        bit dataMode;
        dataMode = word[9] && rdSeen;
        sendBits(word, 10);
        MOSI = 1'($urandom);
        checks++;
        if (rx_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rxValid: got %b expected 1", rx_valid);
        end
        checks++;
        if (rx_data !== word) begin
            failures++;
            $display("[TB] FAIL rxData: got %h expected %h", rx_data, word);
        end
        lastRx = word;
        if (word[9] && !rdSeen)
            rdSeen = 1'b1;
        if (dataMode) begin
            for (int d = 0; d < txDelay; d++) begin
                tx_valid = 1'b0;
                tick();
                checks++;
                if ({rx_valid, MISO} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL txWait %0d: rx_valid,MISO got %b expected 00", d, {rx_valid, MISO});
                end
            end
            tx_valid = 1'b1;
            tx_data = txByte;
            tick();
            tx_valid = 1'b0;
            tx_data = 8'($urandom);
            for (int b = 7; b >= 0; b--) begin
                checks++;
                if ({rx_valid, MISO} !== {1'b0, txByte[b]}) begin
                    failures++;
                    $display("[TB] FAIL misoBit %0d: rx_valid,MISO got %b expected %b", b, {rx_valid, MISO}, {1'b0, txByte[b]});
                end
                tx_valid = 1'($urandom);
                tick();
            end
            tx_valid = 1'b0;
            checks++;
            if (MISO !== 1'b0) begin
                failures++;
                $display("[TB] FAIL misoAfterRead: got %b expected 0", MISO);
            end
            rdSeen = 1'b0;
        end else begin
            // Not in read-data mode, so tx_valid must never reach MISO.
            tx_valid = 1'b1;
            tx_data = 8'hFF;
            for (int p = 0; p < 3; p++) begin
                tick();
                checks++;
                if ({rx_valid, MISO} !== 2'b00) begin
                    failures++;
                    $display("[TB] FAIL probe %0d: rx_valid,MISO got %b expected 00", p, {rx_valid, MISO});
                end
            end
            tx_valid = 1'b0;
        end
        for (int h = 0; h < extraHold; h++) begin
            MOSI = 1'($urandom);
            tick();
            checks++;
            if ({rx_valid, MISO} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL holdLow %0d: rx_valid,MISO got %b expected 00", h, {rx_valid, MISO});
            end
        end
        SS_n = 1'b1;
        tick();
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frameErrComplete: got %b expected 0", frame_err);
        end
`endif
        tick();
    endtask

    // Deselect after n command bits (0..9): nothing is delivered.
    task automatic abortFrame(input logic [9:0] word, input int n);
        sendBits(word, n);
        SS_n = 1'b1;
        tick();
        checks++;
        if (rx_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abortValid: got %b expected 0", rx_valid);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL frameErrPulse: got %b expected 1", frame_err);
        end
`endif
        tick();
        checks++;
        if ({rx_valid, MISO, rx_data} !== {2'b00, lastRx}) begin
            failures++;
            $display("[TB] FAIL abortHold: got %b_%b_%h expected 0_0_%h", rx_valid, MISO, rx_data, lastRx);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL frameErrOnce: got %b expected 0", frame_err);
        end
`endif
    endtask

    // Read-data frame interrupted after k MISO bits, by deselect or by reset.
    task automatic readInterrupt(input logic [7:0] txByte, input int k, input bit useReset);
        logic [9:0] word;
        word = {2'b11, 8'($urandom)};
        sendBits(word, 10);
        checks++;
        if (rx_data !== word) begin
            failures++;
            $display("[TB] FAIL intRxData: got %h expected %h", rx_data, word);
        end
        lastRx = word;
        tx_valid = 1'b1;
        tx_data = txByte;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < k; i++) begin
            checks++;
            if (MISO !== txByte[7-i]) begin
                failures++;
                $display("[TB] FAIL intMiso %0d: got %b expected %b", i, MISO, txByte[7-i]);
            end
            if (i < k - 1)
                tick();
        end
        SS_n = 1'b1;
        if (useReset)
            rst_n = 1'b0;
        tick();
        checks++;
        if (MISO !== 1'b0) begin
            failures++;
            $display("[TB] FAIL intMisoLow: got %b expected 0", MISO);
        end
        if (useReset) begin
            rdSeen = 1'b0;
            lastRx = '0;
            checks++;
            if ({rx_valid, rx_data} !== 11'b0) begin
                failures++;
                $display("[TB] FAIL intReset: rx_valid,rx_data got %b_%h expected 0_000", rx_valid, rx_data);
            end
            rst_n = 1'b1;
        end else begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
            checks++;
            if (frame_err !== 1'b1) begin
                failures++;
                $display("[TB] FAIL intFrameErr: got %b expected 1", frame_err);
            end
`endif
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        tx_valid = 1'b0;
        tx_data = '0;
        rdSeen = 1'b0;
        lastRx = '0;
        tick();
        tick();
        checks++;
        if ({MISO, rx_valid, rx_data} !== 12'b0) begin
            failures++;
            $display("[TB] FAIL reset: MISO,rx_valid,rx_data got %b_%b_%h expected 0_0_000", MISO, rx_valid, rx_data);
        end
`ifdef SPI_SLAVE_FRAME_ERR_EN
        checks++;
        if (frame_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resetFrameErr: got %b expected 0", frame_err);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        fullFrame(10'h0AA, 0, 8'h00, 0);
        fullFrame(10'h155, 0, 8'h00, 12);
    endtask

    task automatic test_read();
        fullFrame(10'h20F, 0, 8'h00, 0);
        fullFrame(10'h300, 0, 8'hA5, 0);
        fullFrame({2'b10, 8'($urandom)}, 0, 8'h00, 0);
        fullFrame({2'b11, 8'($urandom)}, 2, 8'h3C, 2);
    endtask

    task automatic test_abort();
        abortFrame(10'h0AA, 5);
        abortFrame(10'h3FF, 0);
        abortFrame(10'h2AA, 9);
        fullFrame(10'h0C3, 0, 8'h00, 0);
    endtask

    task automatic test_read_interrupt();
        fullFrame(10'h211, 0, 8'h00, 0);
        readInterrupt(8'hC6, 3, 1'b0);
        fullFrame(10'h322, 1, 8'h81, 0);
        fullFrame(10'h233, 0, 8'h00, 0);
        readInterrupt(8'hE7, 3, 1'b1);
        fullFrame(10'h3FF, 0, 8'h00, 0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 30; f++) begin
            if ($urandom_range(0, 4) == 0)
                abortFrame(10'($urandom), int'($urandom_range(0, 9)));
            else
                fullFrame(10'($urandom), int'($urandom_range(0, 3)), 8'($urandom),
                          int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_read_interrupt();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
